farm_road_detector: RTL and testbench

- Produces the farm-road `Sensor` request consumed by the traffic light FSM, from a raw, bouncy vehicle-detector input.
- Synchronises and debounces the raw input, counts waiting vehicles, and holds the request until the farm road is serviced.
- Uses the farm-road-green indication from the light controller as the acknowledge.
- Sits between the board input pin and the traffic light FSM, running on the 100 Hz domain via a tick enable.

---
 rtl/farm_road_detector_if.sv | 23 ++
 rtl/farm_road_detector.sv | 147 ++++++++++++++
 tb/tb_farm_road_detector.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/farm_road_detector_if.sv
// Signal bundle between the farm-road detector and its environment: the detector
// input, the light-controller acknowledge, the request and the debug outputs.
interface farm_road_detector_if #(
  parameter int CNT_W = 4
);
  logic             Tick;
  logic             RawSensor;
  logic             FrGreen;
  logic             Sensor;
  logic [CNT_W-1:0] CarCount;
  logic             Overflow;
  logic [1:0]       State;

  modport master (
    output Tick, RawSensor, FrGreen,
    input  Sensor, CarCount, Overflow, State
  );

  modport slave (
    input  Tick, RawSensor, FrGreen,
    output Sensor, CarCount, Overflow, State
  );
endinterface

// File: rtl/farm_road_detector.sv
// Turns a bouncy vehicle-detector pin into a held farm-road request. The request is
// acknowledged by farm-road green, and each car departs after DEPART_TICKS of green.
module farm_road_detector #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int DEPART_TICKS   = 50,
  parameter int HOLDOFF_TICKS  = 100,
  parameter int CNT_W          = 4
) (
  input logic                 ClkIn,
  input logic                 Resetn,
  farm_road_detector_if.slave bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int DEP_W = $clog2(DEPART_TICKS + 1);
  localparam int HO_W  = $clog2(HOLDOFF_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             arrival_q, arrival_d;
  logic [DEP_W-1:0] dep_cnt_q, dep_cnt_d;
  logic             departure;
  logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic             sensor_q, sensor_d;

  // NOTE: every variable written in an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    if (bus.Tick) begin
      if (sync2_q != deb_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
          deb_d    = sync2_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_d = '0;
      end
    end
    // Only rising debounced edges are vehicles; the pulse is registered one cycle.
    arrival_d = deb_d & ~deb_q;
  end

  always_comb begin
    dep_cnt_d = '0;
    departure = 1'b0;
    if (state_q == ST_SERVICE && bus.FrGreen) begin
      dep_cnt_d = dep_cnt_q;
      if (bus.Tick) begin
        if (dep_cnt_q == DEP_W'(DEPART_TICKS - 1)) begin
          dep_cnt_d = '0;
          departure = (count_q != '0);
        end else begin
          dep_cnt_d = dep_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (arrival_q && !departure) begin
      if (count_q == '1) ovf_d = 1'b1;
      else               count_d = count_q + 1'b1;
    end else if (departure && !arrival_q) begin
      count_d = count_q - 1'b1;
    end
  end

  // Decisions use count_d so the request drops on the same edge the last car leaves.
  always_comb begin
    state_d  = state_q;
    ho_cnt_d = '0;
    unique case (state_q)
      ST_IDLE:    if (arrival_q) state_d = ST_REQUEST;
      ST_REQUEST: if (bus.FrGreen) state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (count_d == '0)     state_d = ST_HOLDOFF;
        else if (!bus.FrGreen) state_d = ST_REQUEST;
      end
      ST_HOLDOFF: begin
        ho_cnt_d = ho_cnt_q;
        if (bus.Tick) begin
          if (ho_cnt_q == HO_W'(HOLDOFF_TICKS - 1)) begin
            ho_cnt_d = '0;
            state_d  = (count_d != '0) ? ST_REQUEST : ST_IDLE;
          end else begin
            ho_cnt_d = ho_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sensor_d = (state_d == ST_REQUEST) || (state_d == ST_SERVICE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge ClkIn or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      db_cnt_q  <= '0;
      arrival_q <= 1'b0;
      dep_cnt_q <= '0;
      ho_cnt_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      sensor_q  <= 1'b0;
    end else begin
      sync1_q   <= bus.RawSensor;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      arrival_q <= arrival_d;
      dep_cnt_q <= dep_cnt_d;
      ho_cnt_q  <= ho_cnt_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      sensor_q  <= sensor_d;
    end
  end

  assign bus.Sensor   = sensor_q;
  assign bus.CarCount = count_q;
  assign bus.Overflow = ovf_q;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_farm_road_detector.sv
// Directed bench for farm_road_detector: debounce latency, glitch rejection, service
// and holdoff timing, light timeout, counter saturation and asynchronous reset.
module tb_farm_road_detector;

  logic ClkIn = 1'b0;
  logic Resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  farm_road_detector_if #(.CNT_W(4)) bus ();

  farm_road_detector #(
    .DEBOUNCE_TICKS(4),
    .DEPART_TICKS  (50),
    .HOLDOFF_TICKS (100),
    .CNT_W         (4)
  ) dut (
    .ClkIn (ClkIn),
    .Resetn(Resetn),
    .bus   (bus)
  );

  always #5 ClkIn = ~ClkIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge ClkIn);
  endtask

  task automatic do_reset();
    Resetn        = 1'b0;
    bus.Tick      = 1'b1;
    bus.RawSensor = 1'b0;
    bus.FrGreen   = 1'b0;
    cycles(2);
    Resetn = 1'b1;
    cycles(1);
  endtask

  // One clean vehicle: high long enough to debounce, low long enough to settle.
  task automatic car_arrive();
    bus.RawSensor = 1'b1;
    cycles(7);
    bus.RawSensor = 1'b0;
    cycles(7);
  endtask

  initial begin
    Resetn        = 1'b0;
    bus.Tick      = 1'b1;
    bus.RawSensor = 1'b0;
    bus.FrGreen   = 1'b0;

    // Reset values and first-arrival latency (2 sync + 4 debounce + 1 pulse).
    do_reset();
    check("rst_sensor",   bus.Sensor,   0);
    check("rst_count",    bus.CarCount, 0);
    check("rst_overflow", bus.Overflow, 0);
    check("rst_state",    bus.State,    0);
    bus.RawSensor = 1'b1;
    cycles(6);
    check("lat_count_early", bus.CarCount, 0);
    check("lat_state_early", bus.State,    0);
    cycles(1);
    check("lat_count", bus.CarCount, 1);
    check("lat_sensor", bus.Sensor,  1);
    check("lat_state",  bus.State,   1);
    bus.RawSensor = 1'b0;
    cycles(8);
    check("fall_ignored", bus.CarCount, 1);

    // Short glitches never debounce; farm-road green in IDLE is ignored.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.RawSensor = 1'b1;
      cycles(3);
      bus.RawSensor = 1'b0;
      cycles(5);
    end
    check("glitch_count",  bus.CarCount, 0);
    check("glitch_sensor", bus.Sensor,   0);
    bus.FrGreen = 1'b1;
    cycles(60);
    check("idle_green_state", bus.State,    0);
    check("idle_green_count", bus.CarCount, 0);
    bus.FrGreen = 1'b0;

    // Debounce only advances on Tick.
    do_reset();
    bus.Tick      = 1'b0;
    bus.RawSensor = 1'b1;
    cycles(20);
    check("notick_count", bus.CarCount, 0);
    bus.Tick = 1'b1;
    cycles(4);
    check("tick_count_early", bus.CarCount, 0);
    cycles(1);
    check("tick_count", bus.CarCount, 1);
    bus.RawSensor = 1'b0;
    cycles(8);

    // Three cars served 50 Ticks apart, then 100-Tick holdoff with green still high.
    do_reset();
    repeat (3) car_arrive();
    check("svc_count3",  bus.CarCount, 3);
    check("svc_req",     bus.State,    1);
    bus.FrGreen = 1'b1;
    cycles(1);
    check("svc_enter",   bus.State,    2);
    check("svc_sensor",  bus.Sensor,   1);
    cycles(49);
    check("svc_pre50",   bus.CarCount, 3);
    cycles(1);
    check("svc_at50",    bus.CarCount, 2);
    cycles(49);
    check("svc_pre100",  bus.CarCount, 2);
    cycles(1);
    check("svc_at100",   bus.CarCount, 1);
    check("svc_sens100", bus.Sensor,   1);
    cycles(49);
    check("svc_pre150",  bus.State,    2);
    cycles(1);
    check("svc_at150",   bus.CarCount, 0);
    check("svc_hold",    bus.State,    3);
    check("svc_drop",    bus.Sensor,   0);
    cycles(99);
    check("hold_pre",    bus.State,    3);
    cycles(1);
    check("hold_idle",   bus.State,    0);
    check("hold_sensor", bus.Sensor,   0);
    bus.FrGreen = 1'b0;

    // Light times out with a car still waiting, then is re-granted.
    do_reset();
    repeat (2) car_arrive();
    bus.FrGreen = 1'b1;
    cycles(1);
    check("to_enter",  bus.State,    2);
    cycles(50);
    check("to_count1", bus.CarCount, 1);
    cycles(9);
    bus.FrGreen = 1'b0;
    cycles(1);
    check("to_state",  bus.State,    1);
    check("to_sensor", bus.Sensor,   1);
    check("to_count",  bus.CarCount, 1);
    bus.FrGreen = 1'b1;
    cycles(1);
    check("re_enter",  bus.State,    2);
    cycles(49);
    check("re_pre",    bus.CarCount, 1);
    cycles(1);
    check("re_count",  bus.CarCount, 0);
    check("re_hold",   bus.State,    3);
    bus.FrGreen = 1'b0;

    // Saturation at 15; overflow is sticky across a departure.
    do_reset();
    repeat (15) car_arrive();
    check("sat15_count", bus.CarCount, 15);
    check("sat15_ovf",   bus.Overflow, 0);
    car_arrive();
    check("sat16_count", bus.CarCount, 15);
    check("sat16_ovf",   bus.Overflow, 1);
    bus.FrGreen = 1'b1;
    cycles(51);
    check("sat_dep_count", bus.CarCount, 14);
    check("sat_dep_ovf",   bus.Overflow, 1);
    check("sat_dep_state", bus.State,    2);
    bus.FrGreen = 1'b0;

    // Asynchronous reset in the middle of SERVICE, checked before any clock edge.
    do_reset();
    repeat (5) car_arrive();
    bus.FrGreen = 1'b1;
    cycles(10);
    check("ar_state_pre", bus.State,    2);
    check("ar_count_pre", bus.CarCount, 5);
    #2 Resetn = 1'b0;
    #1;
    check("ar_sensor", bus.Sensor,   0);
    check("ar_count",  bus.CarCount, 0);
    check("ar_ovf",    bus.Overflow, 0);
    check("ar_state",  bus.State,    0);
    @(negedge ClkIn);
    bus.FrGreen = 1'b0;
    Resetn      = 1'b1;
    cycles(2);
    check("ar_after_state", bus.State, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
